// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: serialises committed stores and load-buffer reads onto one
// single-ported memory and returns tagged load data.
module dmem_port_arbiter #(
    parameter int unsigned NUM_LB = 2,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_LB-1:0]       lb_req,
    input  logic [NUM_LB*XLEN-1:0]  lb_addr,
    input  logic [NUM_LB*3-1:0]     lb_size,
    input  logic [NUM_LB*TAG_W-1:0] lb_tag,
    output logic [NUM_LB-1:0]       lb_mem_busy,
    input  logic                    st_req,
    input  logic [XLEN-1:0]         st_addr,
    input  logic [XLEN-1:0]         st_data,
    input  logic [2:0]              st_size,
    output logic                    st_grant,
    output logic [1:0]              mem_command,
    output logic [XLEN-1:0]         mem_addr,
    output logic [XLEN-1:0]         mem_wdata,
    output logic [2:0]              mem_size,
    input  logic                    mem_ack,
    input  logic [XLEN-1:0]         mem_rdata,
    output logic                    ld_done_valid,
    output logic [TAG_W-1:0]        ld_done_tag,
    output logic [XLEN-1:0]         ld_done_data
);
    localparam int unsigned PTR_W = (NUM_LB > 1) ? $clog2(NUM_LB) : 1;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [1:0] {StIdle, StLoad, StStore} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rr_q, rr_next, win_idx;
    logic              win_found, load_grant;
    logic [XLEN-1:0]   addr_q, wdata_q, done_data_q;
    logic [2:0]        size_q;
    logic [TAG_W-1:0]  tag_q, done_tag_q;
    logic              st_grant_q, done_valid_q;

    logic [XLEN-1:0]   lb_addr_a [NUM_LB];
    logic [2:0]        lb_size_a [NUM_LB];
    logic [TAG_W-1:0]  lb_tag_a  [NUM_LB];

    for (genvar i = 0; i < NUM_LB; i++) begin : g_unpack
        assign lb_addr_a[i] = lb_addr[i*XLEN +: XLEN];
        assign lb_size_a[i] = lb_size[i*3 +: 3];
        assign lb_tag_a[i]  = lb_tag[i*TAG_W +: TAG_W];
    end

    // Round-robin search starting at rr_q; rr_q + k never exceeds 2*NUM_LB-2.
    always_comb begin
        int unsigned      sum;
        logic [PTR_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        sum       = 0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_LB; k++) begin
            sum = 32'(rr_q) + k;
            if (sum >= NUM_LB) sum = sum - NUM_LB;
            cand = PTR_W'(sum);
            if (!win_found && lb_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign load_grant = (state_q == StIdle) && !st_req && win_found;
    assign rr_next    = (32'(win_idx) == NUM_LB - 1) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (st_req)         state_d = StStore;
                else if (win_found) state_d = StLoad;
            end
            StLoad, StStore: if (mem_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_command = BUS_NONE;
        unique case (state_q)
            StLoad:  mem_command = BUS_LOAD;
            StStore: mem_command = BUS_STORE;
            default: mem_command = BUS_NONE;
        endcase
        for (int i = 0; i < NUM_LB; i++) begin
            lb_mem_busy[i] = !(load_grant && (win_idx == PTR_W'(i)));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            tag_q        <= '0;
            st_grant_q   <= 1'b0;
            done_valid_q <= 1'b0;
            done_tag_q   <= '0;
            done_data_q  <= '0;
        end else begin
            st_grant_q   <= 1'b0;
            done_valid_q <= 1'b0;
            if (state_q == StIdle) begin
                if (st_req) begin
                    addr_q     <= st_addr;
                    wdata_q    <= st_data;
                    size_q     <= st_size;
                    st_grant_q <= 1'b1;
                end else if (win_found) begin
                    addr_q <= lb_addr_a[win_idx];
                    size_q <= lb_size_a[win_idx];
                    tag_q  <= lb_tag_a[win_idx];
                    rr_q   <= rr_next;
                end
            end else if (state_q == StLoad && mem_ack) begin
                done_valid_q <= 1'b1;
                done_tag_q   <= tag_q;
                done_data_q  <= mem_rdata;
            end
        end
    end

    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_size      = size_q;
    assign st_grant      = st_grant_q;
    assign ld_done_valid = done_valid_q;
    assign ld_done_tag   = done_tag_q;
    assign ld_done_data  = done_data_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus queues expected memory transactions and
// load returns; a negedge monitor pops and compares them as the DUT presents them.
module tb_dmem_port_arbiter;
    localparam int unsigned NUM_LB = 2;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned TAG_W  = 5;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          len;
    } txn_t;
    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
    } done_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        lb_req = '0;
    logic [31:0]       la [2];
    logic [2:0]        ls [2];
    logic [4:0]        lt [2];
    logic [63:0]       lb_addr;
    logic [5:0]        lb_size;
    logic [9:0]        lb_tag;
    logic [1:0]        lb_mem_busy;
    logic              st_req = 1'b0;
    logic [31:0]       st_addr = '0, st_data = '0;
    logic [2:0]        st_size = '0;
    logic              st_grant;
    logic [1:0]        mem_command;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;
    logic [2:0]        mem_size;
    logic              mem_ack;
    logic              ld_done_valid;
    logic [4:0]        ld_done_tag;
    logic [31:0]       ld_done_data;

    assign lb_addr = {la[1], la[0]};
    assign lb_size = {ls[1], ls[0]};
    assign lb_tag  = {lt[1], lt[0]};

    dmem_port_arbiter #(.NUM_LB(NUM_LB), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .lb_req(lb_req), .lb_addr(lb_addr), .lb_size(lb_size), .lb_tag(lb_tag),
        .lb_mem_busy(lb_mem_busy),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_grant(st_grant),
        .mem_command(mem_command), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ld_done_valid(ld_done_valid), .ld_done_tag(ld_done_tag), .ld_done_data(ld_done_data)
    );

    always #5 clock = ~clock;

    int    checks = 0, errors = 0;
    txn_t  exp_txn[$];
    done_t exp_done[$];
    int    exp_grant = 0;
    int    ack_delay = 1;
    int    ack_cnt = 0;
    logic  spur_ack = 1'b0;
    logic  auto_drop = 1'b1;
    int    grant_cnt = 0;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic push_load(input logic [31:0] a, input logic [2:0] sz, input logic [4:0] tg,
                             input int len);
        exp_txn.push_back('{cmd: BUS_LOAD, addr: a, size: sz, wdata: 32'h0, len: len});
        exp_done.push_back('{tag: tg, data: rd_model(a)});
    endtask

    // Memory model: acks the ack_delay-th cycle of each command, plus optional spurious ack.
    always @(negedge clock) begin
        mem_ack   = spur_ack;
        mem_rdata = 32'h0;
        if (reset && mem_command != BUS_NONE) begin
            if (ack_cnt == 0) ack_cnt = ack_delay;
            ack_cnt--;
            if (ack_cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_model(mem_addr);
            end
        end else begin
            ack_cnt = 0;
        end
    end

    logic in_txn = 1'b0;
    int   cyc = 0;
    txn_t cur;

    always @(negedge clock) begin
        if (!reset) begin
            in_txn = 1'b0;
        end else begin
            if (mem_command != BUS_NONE) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    cyc    = 1;
                    if (exp_txn.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_cmd: got cmd %0d addr %h, required none",
                                 mem_command, mem_addr);
                        cur = '{cmd: mem_command, addr: mem_addr, size: mem_size,
                                wdata: mem_wdata, len: 0};
                    end else begin
                        cur = exp_txn.pop_front();
                        chk("cmd", 32'(mem_command), 32'(cur.cmd));
                        chk("addr", mem_addr, cur.addr);
                        chk("size", 32'(mem_size), 32'(cur.size));
                        if (cur.cmd == BUS_STORE) chk("wdata", mem_wdata, cur.wdata);
                    end
                end else begin
                    cyc++;
                    chk("hold_cmd", 32'(mem_command), 32'(cur.cmd));
                    chk("hold_addr", mem_addr, cur.addr);
                end
            end else if (in_txn) begin
                in_txn = 1'b0;
                chk("cmd_cycles", 32'(cyc), 32'(cur.len));
                chk("done_timing", 32'(ld_done_valid), 32'(cur.cmd == BUS_LOAD));
            end
            if (ld_done_valid) begin
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got tag %0d, required no pulse", ld_done_tag);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("done_tag", 32'(ld_done_tag), 32'(d.tag));
                    chk("done_data", ld_done_data, d.data);
                end
            end
            if (st_grant) begin
                checks++;
                if (exp_grant == 0) begin
                    errors++;
                    $display("FAIL unexpected_st_grant: got pulse, required none");
                end else begin
                    exp_grant--;
                end
            end
        end
    end

    // Called at posedge+1; releases whichever requester was granted at the coming edge.
    task automatic step();
        logic [1:0] m;
        #1;
        m = ~lb_mem_busy & lb_req;
        if (m != 2'b00) grant_cnt++;
        @(posedge clock);
        #1;
        if (auto_drop) lb_req = lb_req & ~m;
        if (st_grant) st_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_txn.size() != 0 || exp_done.size() != 0 || exp_grant != 0 ||
                mem_command != BUS_NONE || lb_req != 2'b00 || st_req) && n < 80) begin
            step();
            n++;
        end
        checks++;
        if (n >= 80) begin
            errors++;
            $display("FAIL %s_timeout: got %0d txns pending, required 0", name, exp_txn.size());
        end
    endtask

    initial begin
        int g0, n;
        la[0] = '0; la[1] = '0; ls[0] = '0; ls[1] = '0; lt[0] = '0; lt[1] = '0;
        #2 reset = 1'b0;
        #10;
        chk("rst_cmd", 32'(mem_command), 32'(BUS_NONE));
        chk("rst_busy", 32'(lb_mem_busy), 32'h3);
        chk("rst_done", 32'(ld_done_valid), 32'h0);
        chk("rst_grant", 32'(st_grant), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Single load, ack on second command cycle
        la[0] = 32'h100; ls[0] = 3'd2; lt[0] = 5'd5; ack_delay = 2;
        push_load(32'h100, 3'd2, 5'd5, 2);
        lb_req = 2'b01;
        #1 chk("t1_busy_req", 32'(lb_mem_busy), 32'h2);
        step();
        #1 chk("t1_busy_after", 32'(lb_mem_busy), 32'h3);
        wait_done("t1");

        // Spurious ack in IDLE
        spur_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("spur_cmd", 32'(mem_command), 32'(BUS_NONE));
            chk("spur_done", 32'(ld_done_valid), 32'h0);
            chk("spur_grant", 32'(st_grant), 32'h0);
            step();
        end
        spur_ack = 1'b0;

        // Store beats both loads; round-robin pointer is 1 so LB1 follows
        ack_delay = 1;
        st_addr = 32'h200; st_data = 32'h55; st_size = 3'd2; st_req = 1'b1;
        la[0] = 32'h300; ls[0] = 3'd2; lt[0] = 5'd7;
        la[1] = 32'h340; ls[1] = 3'd4; lt[1] = 5'd9;
        lb_req = 2'b11;
        exp_txn.push_back('{cmd: BUS_STORE, addr: 32'h200, size: 3'd2, wdata: 32'h55, len: 1});
        exp_grant = 1;
        push_load(32'h340, 3'd4, 5'd9, 1);
        push_load(32'h300, 3'd2, 5'd7, 1);
        #1 chk("t2_busy_store", 32'(lb_mem_busy), 32'h3);
        wait_done("t2");

        // Long ack with inputs changing underneath
        ack_delay = 5;
        la[0] = 32'h180; ls[0] = 3'd0; lt[0] = 5'd3;
        lb_req = 2'b01;
        push_load(32'h180, 3'd0, 5'd3, 5);
        step();
        la[0] = 32'h999; ls[0] = 3'd4; lt[0] = 5'd6;
        la[1] = 32'h1C0; ls[1] = 3'd1; lt[1] = 5'd4;
        lb_req = 2'b11;
        push_load(32'h1C0, 3'd1, 5'd4, 5);
        push_load(32'h999, 3'd4, 5'd6, 5);
        for (int i = 0; i < 4; i++) begin
            #1 chk("t4_busy_hold", 32'(lb_mem_busy), 32'h3);
            step();
        end
        wait_done("t4");

        // Async reset in the middle of a load
        ack_delay = 4;
        la[0] = 32'h100; ls[0] = 3'd2; lt[0] = 5'd2;
        lb_req = 2'b01;
        exp_txn.push_back('{cmd: BUS_LOAD, addr: 32'h100, size: 3'd2, wdata: 32'h0, len: 0});
        step();
        step();
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_cmd", 32'(mem_command), 32'(BUS_NONE));
        chk("rst_mid_busy", 32'(lb_mem_busy), 32'h3);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rst_mid_done", 32'(ld_done_valid), 32'h0);
        chk("rst_mid_cmd2", 32'(mem_command), 32'(BUS_NONE));
        #1 reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_mid_done2", 32'(ld_done_valid), 32'h0);
        wait_done("t5");

        // Round-robin with both requests held; pointer restarts at 0 after reset
        ack_delay = 1;
        auto_drop = 1'b0;
        la[0] = 32'h100; ls[0] = 3'd2; lt[0] = 5'd2;
        la[1] = 32'h140; ls[1] = 3'd1; lt[1] = 5'd8;
        push_load(32'h100, 3'd2, 5'd2, 1);
        push_load(32'h140, 3'd1, 5'd8, 1);
        push_load(32'h100, 3'd2, 5'd2, 1);
        lb_req = 2'b11;
        g0 = grant_cnt;
        n  = 0;
        while (grant_cnt < g0 + 3 && n < 40) begin
            step();
            n++;
        end
        lb_req = 2'b00;
        auto_drop = 1'b1;
        chk("rr_grants", 32'(grant_cnt - g0), 32'd3);
        wait_done("t6");

        repeat (3) @(posedge clock);
        #1;
        chk("end_txn_q", 32'(exp_txn.size()), 32'd0);
        chk("end_done_q", 32'(exp_done.size()), 32'd0);
        chk("end_grant", 32'(exp_grant), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences the single-ported data memory between NUM_LB load buffers and the committed-store path from the ROB head.
- Each load buffer raises a memory-read request once its load is clear of pending stores. The committing store raises a write request.
- The arbiter grants one transaction at a time, drives the memory command, waits for the memory acknowledge, and returns load data tagged with the ROB tag.
- Sits between the load buffers / ROB store commit and the MEM-stage memory interface; generates each load buffer's mem_busy.

Parameters:
- NUM_LB, 2, number of load-buffer requesters (≥1).
- XLEN, `XLEN, address/data width.
- TAG_W, `ROB_TAG_LEN, ROB tag width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- lb_req  in  NUM_LB  per-buffer read request (level; held until granted).
- lb_addr  in  NUM_LB*XLEN  per-buffer load address.
- lb_size  in  NUM_LB*3  per-buffer load size/sign (funct3).
- lb_tag  in  NUM_LB*TAG_W  per-buffer ROB tag.
- lb_mem_busy  out  NUM_LB  per-buffer busy; low only for the buffer granted this cycle.
- st_req  in  1  committed store wants memory (level; held until st_grant).
- st_addr  in  XLEN  store address.
- st_data  in  XLEN  store data.
- st_size  in  3  store size.
- st_grant  out  1  one-cycle pulse: store accepted.
- mem_command  out  2  BUS_NONE / BUS_LOAD / BUS_STORE.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_size  out  3  memory access size.
- mem_ack  in  1  memory completes current transaction.
- mem_rdata  in  XLEN  read data, valid with mem_ack.
- ld_done_valid  out  1  one-cycle pulse: load data returned.
- ld_done_tag  out  TAG_W  ROB tag of returned load.
- ld_done_data  out  XLEN  returned load data (raw; extension is done downstream).

Behaviour:
- **FSM states:** IDLE, LOAD, STORE. Reset value is IDLE.
- **Reset values:** all registered outputs 0; mem_command = BUS_NONE; rr_ptr = 0.
- **IDLE arbitration** (combinational, same cycle):
  - st_req has absolute priority over all loads.
  - Otherwise the load winner is chosen round-robin: first lb_req[i] set, searching from rr_ptr upward and wrapping modulo NUM_LB.
- **lb_mem_busy[i]** = 0 only if state == IDLE, st_req == 0, and i is the load winner; otherwise 1. This holds during reset too.
- **Grant edge** (IDLE with a winner):
  - Latch addr, size, wdata or tag of the winner into transaction registers.
  - Go to STORE or LOAD.
  - For a store, st_grant pulses in the following cycle.
  - For a load, rr_ptr advances to winner+1 (wrap to 0 at NUM_LB).
- **LOAD / STORE states:**
  - mem_command = BUS_LOAD or BUS_STORE, driven from the latched registers and held stable every cycle until mem_ack is sampled high.
  - On the ack edge, return to IDLE and drive mem_command = BUS_NONE the next cycle.
- **LOAD completion:** on the ack edge, capture mem_rdata and the latched tag. ld_done_valid = 1 for exactly the next cycle.
- **Latency:** request sampled in cycle N; command visible in N+1; ack in cycle M ≥ N+1 gives done / IDLE in M+1. Back-to-back transactions need one IDLE cycle between them.
- **Boundary conditions:**
  - mem_ack while IDLE is ignored.
  - lb_req dropping while not granted is legal and is simply not selected.
  - Request inputs changing while LOAD/STORE is active have no effect on the in-flight transaction.
  - A single requester with NUM_LB == 1 is always the winner when st_req = 0.
- **Reset mid-transaction:** immediately returns to IDLE with BUS_NONE. The in-flight transaction is dropped with no done/grant pulse; requesters must re-request.

Test Plan:
- Single load: lb_req = 01, lb_addr[0] = 0x100, tag 5, mem_ack 2 cycles after command → mem_command = BUS_LOAD addr 0x100 for 2 cycles; ld_done_valid pulse with tag 5, data = mem_rdata (0xDEADBEEF); lb_mem_busy[0] low only in the request cycle.
- Store vs load collision: st_req = 1 (addr 0x200, data 0x55) and lb_req = 11 in the same IDLE cycle → store granted first, st_grant pulse, lb_mem_busy = 11; loads are served afterwards.
- Round-robin: lb_req = 11 held, immediate acks → grants alternate LB0, LB1, LB0; rr_ptr wraps to 0.
- Hold stability: mem_ack delayed 5 cycles while lb_addr/lb_req change → mem_addr and mem_command constant across all 5 cycles; no second grant.
- Async reset mid-LOAD: assert reset = 0 between clock edges → mem_command = BUS_NONE immediately, no ld_done_valid; after release, a re-issued request is served normally.
- Spurious ack: mem_ack = 1 in IDLE with no requests → no state change, no pulses.
